pipelined_instruction_memory: RTL and testbench

PIPELINED_INSTRUCTION_MEMORY -- requirements
Module: pipelined_instruction_memory

---
 rtl/pipelined_instruction_memory.sv | 123 ++++++++++++
 tb/tb_pipelined_instruction_memory.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_instruction_memory.sv
// Instruction memory with a valid/ready fetch port and a programmable access latency.
// A fetch is accepted in IDLE. It then spends WAIT_STATES cycles in WAIT, and the
// response is held in RESP until the consumer takes it. A separate program-load
// port writes words at any time, but not while reset is asserted.
// Stored words are never cleared by reset.
//
// state | meaning
// IDLE  | ready for a fetch (req_ready=1 once out of reset)
// WAIT  | counting access wait states
// RESP  | response held until rsp_ready
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   req_valid/req_ready/req_addr  fetch request (byte address)
//   rsp_valid/rsp_ready           response handshake
//   rsp_data/rsp_err              fetched word / misaligned-or-out-of-range flag
//   prog_we/prog_addr/prog_data   program-load write port (word index)
module pipelined_instruction_memory #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_WIDTH-1:0]    req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_data,
  output logic                     rsp_err,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [DATA_WIDTH-1:0]    prog_data
);

  localparam int BW = $clog2(DATA_WIDTH / 8);
  localparam int IW = $clog2(DEPTH);
  localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  state, state_nxt;
  logic                    ready_en;
  logic [3:0]              wait_cnt;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    err_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    accept;
  logic [ADDR_WIDTH-1:0]   cap_addr;
  logic [ADDR_WIDTH-1:0]   cap_idx;
  logic                    cap_err;
  logic                    enter_resp;

  assign accept     = (state == S_IDLE) && req_valid && req_ready;
  assign enter_resp = (state_nxt == S_RESP) && (state != S_RESP);

  // With zero wait states the capture happens on the accepting edge itself,
  // before addr_q holds the address, so read straight from the port then.
  assign cap_addr = (state == S_IDLE) ? req_addr : addr_q;
  assign cap_idx  = cap_addr >> BW;
  assign cap_err  = (|cap_addr[BW-1:0]) || (cap_idx >= DEPTH_A);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
      S_WAIT: if (wait_cnt == 4'd0) state_nxt = S_RESP;
      S_RESP: if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // outputs
  always_comb begin
    req_ready = (state == S_IDLE) && ready_en;
    rsp_valid = (state == S_RESP);
    rsp_data  = rsp_valid ? data_q : '0;
    rsp_err   = rsp_valid && err_q;
  end

  // ready_en keeps req_ready low until the first edge after reset release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_en <= 1'b0;
      wait_cnt <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (accept) begin
        addr_q   <= req_addr;
        wait_cnt <= CNT_LOAD;
      end else if (state == S_WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      // memory read sees the pre-edge contents, so a same-edge write returns the old word
      if (enter_resp) begin
        err_q  <= cap_err;
        data_q <= cap_err ? '0 : mem[cap_idx[IW-1:0]];
      end
    end
  end

  // program-load port; rst blocks writes but never clears contents
  always_ff @(posedge clk or posedge rst) begin
    if (!rst && prog_we && (32'(prog_addr) < 32'(DEPTH)))
      mem[prog_addr] <= prog_data;
  end

endmodule

// File: tb/tb_pipelined_instruction_memory.sv
module tb_pipelined_instruction_memory;

  logic        clk;
  logic        rst;

  logic        a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready, a_rsp_err, a_prog_we;
  logic [31:0] a_req_addr, a_rsp_data, a_prog_data;
  logic [3:0]  a_prog_addr;

  logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, b_rsp_err, b_prog_we;
  logic [31:0] b_req_addr, b_rsp_data, b_prog_data;
  logic [3:0]  b_prog_addr;

  int checks = 0;
  int errors = 0;

  pipelined_instruction_memory #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(16), .WAIT_STATES(2)
  ) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_addr(a_req_addr),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_data(a_rsp_data),
    .rsp_err(a_rsp_err),
    .prog_we(a_prog_we), .prog_addr(a_prog_addr), .prog_data(a_prog_data)
  );

  pipelined_instruction_memory #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(16), .WAIT_STATES(0)
  ) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data),
    .rsp_err(b_rsp_err),
    .prog_we(b_prog_we), .prog_addr(b_prog_addr), .prog_data(b_prog_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic load_a(input logic [3:0] addr, input logic [31:0] data);
    a_prog_we = 1'b1; a_prog_addr = addr; a_prog_data = data;
    step();
    a_prog_we = 1'b0;
  endtask

  // Accept a fetch, measure the cycle in which rsp_valid is first seen
  // (1 = cycle right after the accepting edge), check the response, then take it.
  task automatic fetch_a(input string tag, input logic [31:0] addr,
                         input logic [31:0] exp_data, input logic exp_err);
    int n;
    a_req_valid = 1'b1; a_req_addr = addr;
    step();
    a_req_valid = 1'b0;
    n = 1;
    while (!a_rsp_valid && n < 20) begin
      step();
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'd3);
    check({tag, "_data"}, a_rsp_data, exp_data);
    check({tag, "_err"}, {31'd0, a_rsp_err}, {31'd0, exp_err});
    a_rsp_ready = 1'b1;
    step();
    check({tag, "_vld_after"}, {31'd0, a_rsp_valid}, 32'd0);
    check({tag, "_data_after"}, a_rsp_data, 32'd0);
    check({tag, "_rdy_after"}, {31'd0, a_req_ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    a_req_valid = 0; a_req_addr = 0; a_rsp_ready = 1; a_prog_we = 0; a_prog_addr = 0; a_prog_data = 0;
    b_req_valid = 0; b_req_addr = 0; b_rsp_ready = 1; b_prog_we = 0; b_prog_addr = 0; b_prog_data = 0;

    // reset state
    step();
    check("rst_req_ready", {31'd0, a_req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
    check("rst_rsp_data", a_rsp_data, 32'd0);
    check("rst_rsp_err", {31'd0, a_rsp_err}, 32'd0);
    step();
    rst = 1'b0;
    check("rel_req_ready_low", {31'd0, a_req_ready}, 32'd0);
    step();
    check("rel_req_ready_high", {31'd0, a_req_ready}, 32'd1);

    load_a(4'd3, 32'h0064A423);
    load_a(4'd5, 32'hAAAA0005);
    load_a(4'd7, 32'h11111111);
    load_a(4'd15, 32'h0F0F0F0F);

    // basic fetch and error cases
    fetch_a("f0C", 32'h0000000C, 32'h0064A423, 1'b0);
    fetch_a("f0E", 32'h0000000E, 32'h0, 1'b1);
    fetch_a("f40", 32'h00000040, 32'h0, 1'b1);
    fetch_a("f3C", 32'h0000003C, 32'h0F0F0F0F, 1'b0);
    fetch_a("fbig", 32'h80000014, 32'h0, 1'b1);

    // hold response under back-pressure; stray req_valid is ignored
    a_rsp_ready = 1'b0;
    a_req_valid = 1'b1; a_req_addr = 32'h0C;
    step();
    a_req_valid = 1'b0;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      check("hold_vld", {31'd0, a_rsp_valid}, 32'd1);
      check("hold_data", a_rsp_data, 32'h0064A423);
      check("hold_rdy", {31'd0, a_req_ready}, 32'd0);
      if (i == 1) begin a_req_valid = 1'b1; a_req_addr = 32'h14; end
      if (i == 2) a_req_valid = 1'b0;
      step();
    end
    a_rsp_ready = 1'b1;
    step();
    check("hold_taken", {31'd0, a_rsp_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("no_queue_vld", {31'd0, a_rsp_valid}, 32'd0);
      check("no_queue_rdy", {31'd0, a_req_ready}, 32'd1);
      step();
    end

    // write during WAIT is seen by the fetch
    a_req_valid = 1'b1; a_req_addr = 32'h14;
    step();
    a_req_valid = 1'b0;
    a_prog_we = 1'b1; a_prog_addr = 4'd5; a_prog_data = 32'hFE420AE3;
    step();
    a_prog_we = 1'b0;
    step();
    check("wwait_vld", {31'd0, a_rsp_valid}, 32'd1);
    check("wwait_data", a_rsp_data, 32'hFE420AE3);
    step();

    // write on the capture edge returns the old word
    a_req_valid = 1'b1; a_req_addr = 32'h14;
    step();
    a_req_valid = 1'b0;
    step();
    a_prog_we = 1'b1; a_prog_addr = 4'd5; a_prog_data = 32'h12345678;
    step();
    a_prog_we = 1'b0;
    check("wcap_vld", {31'd0, a_rsp_valid}, 32'd1);
    check("wcap_data", a_rsp_data, 32'hFE420AE3);
    step();
    fetch_a("f14_new", 32'h14, 32'h12345678, 1'b0);

    // reset in WAIT drops the fetch and blocks writes
    a_req_valid = 1'b1; a_req_addr = 32'h0C;
    step();
    a_req_valid = 1'b0;
    rst = 1'b1;
    a_prog_we = 1'b1; a_prog_addr = 4'd7; a_prog_data = 32'h22222222;
    #1;
    check("rstw_vld", {31'd0, a_rsp_valid}, 32'd0);
    check("rstw_rdy", {31'd0, a_req_ready}, 32'd0);
    step();
    step();
    rst = 1'b0;
    a_prog_we = 1'b0;
    check("rstw_rel_rdy_low", {31'd0, a_req_ready}, 32'd0);
    step();
    check("rstw_rel_rdy_high", {31'd0, a_req_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("rstw_lost", {31'd0, a_rsp_valid}, 32'd0);
      step();
    end
    fetch_a("f0C_post", 32'h0C, 32'h0064A423, 1'b0);
    fetch_a("f1C_post", 32'h1C, 32'h11111111, 1'b0);

    // zero wait states
    b_prog_we = 1'b1; b_prog_addr = 4'd0; b_prog_data = 32'hCAFEF00D;
    step();
    b_prog_we = 1'b0;
    b_req_valid = 1'b1; b_req_addr = 32'h0;
    step();
    b_req_valid = 1'b0;
    check("ws0_vld", {31'd0, b_rsp_valid}, 32'd1);
    check("ws0_data", b_rsp_data, 32'hCAFEF00D);
    check("ws0_err", {31'd0, b_rsp_err}, 32'd0);
    check("ws0_rdy", {31'd0, b_req_ready}, 32'd0);
    step();
    check("ws0_taken", {31'd0, b_rsp_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
